// File: rtl/sni_hello_extractor.sv
// sni_hello_extractor
// Walks the byte stream of a TLS record, finds the server_name extension of a
// ClientHello and streams the host name out two bytes per cycle toward the
// SNI pattern matchers.
// Optional build macro: SNI_LOWERCASE_EN folds ASCII 'A'..'Z' name bytes to
// lower case before packing (pad bytes stay 0x00, latency is unchanged).
module sni_hello_extractor (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  input  logic        i_sop,
  input  logic        i_eop,
  output logic [15:0] o_match_data,
  output logic        o_match_data_valid,
  output logic        o_sni_done,
  output logic [15:0] o_sni_len,
  output logic        o_parse_err
);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_REC_HDR  = 4'd1,
    ST_HS_HDR   = 4'd2,
    ST_FIXED    = 4'd3,
    ST_SID_LEN  = 4'd4,
    ST_CS_LEN   = 4'd5,
    ST_COMP_LEN = 4'd6,
    ST_SKIP     = 4'd7,
    ST_EXT_TOT  = 4'd8,
    ST_EXT_HDR  = 4'd9,
    ST_SNI_HDR  = 4'd10,
    ST_NAME     = 4'd11,
    ST_DRAIN    = 4'd12
  } state_t;

  // Version (2) + random (32) occupy byte offsets 9..42 of the record.
  localparam logic [15:0] FIXED_LAST = 16'd33;

  // Optional ASCII case folding of name bytes.
  function automatic logic [7:0] fold_case(input logic [7:0] b);
`ifdef SNI_LOWERCASE_EN
    if ((b >= 8'h41) && (b <= 8'h5A)) begin
      fold_case = b | 8'h20;
    end else begin
      fold_case = b;
    end
`else
    fold_case = b;
`endif
  endfunction

  state_t      state_r, state_nxt;
  state_t      ret_r, ret_nxt;
  state_t      cur_st_s;
  state_t      skip_tgt_s;
  logic [15:0] cnt_r, cnt_nxt;
  logic [15:0] cur_cnt_s;
  logic [7:0]  len_hi_r, len_hi_nxt;
  logic [15:0] ext_rem_r, ext_rem_nxt;
  logic        type_nz_r, type_nz_nxt;
  logic [15:0] skip_rem_r, skip_rem_nxt;
  logic [15:0] name_len_r, name_len_nxt;
  logic [7:0]  hi_r, hi_nxt;
  logic [15:0] match_data_r, match_data_nxt;
  logic        match_valid_r, match_valid_nxt;
  logic        sni_done_r, sni_done_nxt;
  logic [15:0] sni_len_r, sni_len_nxt;
  logic        parse_err_r, parse_err_nxt;
  logic        skip_go_s;
  logic [15:0] skip_len_s;
  logic [15:0] field_len_s;
  logic [15:0] ext_left_s;
  logic [7:0]  name_byte_s;

  assign o_match_data       = match_data_r;
  assign o_match_data_valid = match_valid_r;
  assign o_sni_done         = sni_done_r;
  assign o_sni_len          = sni_len_r;
  assign o_parse_err        = parse_err_r;

  // Next-state and next-output logic: one record byte is consumed per valid cycle.
  always_comb begin
    state_nxt       = state_r;
    ret_nxt         = ret_r;
    cnt_nxt         = cnt_r;
    len_hi_nxt      = len_hi_r;
    ext_rem_nxt     = ext_rem_r;
    type_nz_nxt     = type_nz_r;
    skip_rem_nxt    = skip_rem_r;
    name_len_nxt    = name_len_r;
    hi_nxt          = hi_r;
    match_data_nxt  = match_data_r;
    match_valid_nxt = 1'b0;
    sni_done_nxt    = 1'b0;
    sni_len_nxt     = sni_len_r;
    parse_err_nxt   = 1'b0;
    cur_st_s        = state_r;
    cur_cnt_s       = cnt_r;
    skip_go_s       = 1'b0;
    skip_len_s      = 16'd0;
    skip_tgt_s      = ST_IDLE;
    field_len_s     = {len_hi_r, i_data};
    ext_left_s      = ext_rem_r - 16'd4 - field_len_s;
    name_byte_s     = fold_case(i_data);

    if (i_valid) begin
      // A SOP byte always re-enters the parse at record byte 0.
      if (i_sop) begin
        cur_st_s    = ST_REC_HDR;
        cur_cnt_s   = 16'd0;
        sni_len_nxt = 16'd0;
      end else begin
        cur_st_s    = state_r;
        cur_cnt_s   = cnt_r;
      end
      state_nxt = cur_st_s;
      cnt_nxt   = cur_cnt_s + 16'd1;

      case (cur_st_s)
        ST_IDLE: begin
          cnt_nxt = 16'd0;
        end
        ST_REC_HDR: begin
          if ((cur_cnt_s == 16'd0) && (i_data != 8'h16)) begin
            state_nxt = ST_DRAIN;
            cnt_nxt   = 16'd0;
          end else if (cur_cnt_s == 16'd4) begin
            state_nxt = ST_HS_HDR;
            cnt_nxt   = 16'd0;
          end else begin
            state_nxt = ST_REC_HDR;
          end
        end
        ST_HS_HDR: begin
          if ((cur_cnt_s == 16'd0) && (i_data != 8'h01)) begin
            state_nxt = ST_DRAIN;
            cnt_nxt   = 16'd0;
          end else if (cur_cnt_s == 16'd3) begin
            state_nxt = ST_FIXED;
            cnt_nxt   = 16'd0;
          end else begin
            state_nxt = ST_HS_HDR;
          end
        end
        ST_FIXED: begin
          if (cur_cnt_s == FIXED_LAST) begin
            state_nxt = ST_SID_LEN;
            cnt_nxt   = 16'd0;
          end else begin
            state_nxt = ST_FIXED;
          end
        end
        ST_SID_LEN: begin
          skip_go_s  = 1'b1;
          skip_len_s = {8'h00, i_data};
          skip_tgt_s = ST_CS_LEN;
        end
        ST_CS_LEN: begin
          if (cur_cnt_s == 16'd0) begin
            len_hi_nxt = i_data;
          end else begin
            skip_go_s  = 1'b1;
            skip_len_s = field_len_s;
            skip_tgt_s = ST_COMP_LEN;
          end
        end
        ST_COMP_LEN: begin
          skip_go_s  = 1'b1;
          skip_len_s = {8'h00, i_data};
          skip_tgt_s = ST_EXT_TOT;
        end
        ST_SKIP: begin
          if (skip_rem_r == 16'd1) begin
            state_nxt = ret_r;
            cnt_nxt   = 16'd0;
          end else begin
            state_nxt = ST_SKIP;
          end
        end
        ST_EXT_TOT: begin
          if (cur_cnt_s == 16'd0) begin
            len_hi_nxt = i_data;
          end else begin
            ext_rem_nxt = field_len_s;
            cnt_nxt     = 16'd0;
            // An empty extensions block leaves nothing to search.
            state_nxt   = (field_len_s == 16'd0) ? ST_DRAIN : ST_EXT_HDR;
          end
        end
        ST_EXT_HDR: begin
          case (cur_cnt_s)
            16'd0: type_nz_nxt = (i_data != 8'h00);
            16'd1: type_nz_nxt = type_nz_r | (i_data != 8'h00);
            16'd2: len_hi_nxt  = i_data;
            default: begin
              ext_rem_nxt = ext_left_s;
              if (!type_nz_r) begin
                state_nxt = ST_SNI_HDR;
                cnt_nxt   = 16'd0;
              end else begin
                skip_go_s  = 1'b1;
                skip_len_s = field_len_s;
                skip_tgt_s = (ext_left_s == 16'd0) ? ST_DRAIN : ST_EXT_HDR;
              end
            end
          endcase
        end
        ST_SNI_HDR: begin
          case (cur_cnt_s)
            16'd3: len_hi_nxt = i_data;
            16'd4: begin
              name_len_nxt = field_len_s;
              cnt_nxt      = 16'd0;
              if (field_len_s == 16'd0) begin
                sni_done_nxt = 1'b1;
                sni_len_nxt  = 16'd0;
                state_nxt    = ST_DRAIN;
              end else begin
                state_nxt    = ST_NAME;
              end
            end
            default: state_nxt = ST_SNI_HDR;
          endcase
        end
        ST_NAME: begin
          if (cur_cnt_s[0] == 1'b0) begin
            hi_nxt = name_byte_s;
          end else begin
            match_valid_nxt = 1'b1;
            match_data_nxt  = {hi_r, name_byte_s};
          end
          if (cur_cnt_s == (name_len_r - 16'd1)) begin
            if (cur_cnt_s[0] == 1'b0) begin
              match_valid_nxt = 1'b1;
              match_data_nxt  = {name_byte_s, 8'h00};
            end else begin
              match_valid_nxt = 1'b1;
            end
            sni_done_nxt = 1'b1;
            sni_len_nxt  = name_len_r;
            state_nxt    = ST_DRAIN;
            cnt_nxt      = 16'd0;
          end else begin
            state_nxt    = ST_NAME;
          end
        end
        ST_DRAIN: begin
          cnt_nxt = 16'd0;
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = 16'd0;
        end
      endcase

      // Field skips: a zero length falls straight through to the next field.
      if (skip_go_s) begin
        cnt_nxt = 16'd0;
        if (skip_len_s == 16'd0) begin
          state_nxt = skip_tgt_s;
        end else begin
          state_nxt    = ST_SKIP;
          skip_rem_nxt = skip_len_s;
          ret_nxt      = skip_tgt_s;
        end
      end else begin
        skip_rem_nxt = (cur_st_s == ST_SKIP) ? (skip_rem_r - 16'd1) : skip_rem_r;
      end

      // End of record: truncated if the parse still expected more bytes.
      if (i_eop) begin
        parse_err_nxt = (state_nxt != ST_DRAIN) && (state_nxt != ST_IDLE);
        state_nxt     = ST_IDLE;
        cnt_nxt       = 16'd0;
      end else begin
        parse_err_nxt = 1'b0;
      end
    end else begin
      state_nxt = state_r;
      cnt_nxt   = cnt_r;
    end
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r       <= ST_IDLE;
      ret_r         <= ST_IDLE;
      cnt_r         <= 16'd0;
      len_hi_r      <= 8'd0;
      ext_rem_r     <= 16'd0;
      type_nz_r     <= 1'b0;
      skip_rem_r    <= 16'd0;
      name_len_r    <= 16'd0;
      hi_r          <= 8'd0;
      match_data_r  <= 16'd0;
      match_valid_r <= 1'b0;
      sni_done_r    <= 1'b0;
      sni_len_r     <= 16'd0;
      parse_err_r   <= 1'b0;
    end else begin
      state_r       <= state_nxt;
      ret_r         <= ret_nxt;
      cnt_r         <= cnt_nxt;
      len_hi_r      <= len_hi_nxt;
      ext_rem_r     <= ext_rem_nxt;
      type_nz_r     <= type_nz_nxt;
      skip_rem_r    <= skip_rem_nxt;
      name_len_r    <= name_len_nxt;
      hi_r          <= hi_nxt;
      match_data_r  <= match_data_nxt;
      match_valid_r <= match_valid_nxt;
      sni_done_r    <= sni_done_nxt;
      sni_len_r     <= sni_len_nxt;
      parse_err_r   <= parse_err_nxt;
    end
  end

endmodule

// File: tb/tb_sni_hello_extractor.sv
// tb_sni_hello_extractor: builds ClientHello records, predicts the per-byte
// response from a byte-offset model of the TLS layout and compares every cycle.
module tb_sni_hello_extractor;

  localparam int MAXB = 1024;
  localparam int BIG  = 1 << 30;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [7:0]  data;
  logic        sop;
  logic        eop;
  logic [15:0] match_data;
  logic        match_valid;
  logic        sni_done;
  logic [15:0] sni_len;
  logic        parse_err;

  int          n_cmp;
  int          n_bad;
  int          n_done;
  int          n_err;
  logic [15:0] done_word;
  logic [15:0] exp_len;
  logic [15:0] log_q[$];
  logic [7:0]  rec_q[$];
  logic [7:0]  nm_q[$];

  logic        e_v[MAXB];
  logic [15:0] e_w[MAXB];
  logic        e_d[MAXB];
  logic        e_e[MAXB];
  logic [15:0] m_len;

  sni_hello_extractor dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_valid            (valid),
    .i_data             (data),
    .i_sop              (sop),
    .i_eop              (eop),
    .o_match_data       (match_data),
    .o_match_data_valid (match_valid),
    .o_sni_done         (sni_done),
    .o_sni_len          (sni_len),
    .o_parse_err        (parse_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] lc(input logic [7:0] b);
`ifdef SNI_LOWERCASE_EN
    return ((b >= 8'h41) && (b <= 8'h5A)) ? (b + 8'h20) : b;
`else
    return b;
`endif
  endfunction

  function automatic int rd(input int i);
    if (i < rec_q.size()) return int'(rec_q[i]);
    else return 0;
  endfunction

  task automatic set_name(input string s);
    nm_q.delete();
    for (int i = 0; i < s.len(); i++) nm_q.push_back(s[i]);
  endtask

  task automatic rand_name(input int n);
    nm_q.delete();
    for (int i = 0; i < n; i++) nm_q.push_back(8'($urandom_range(45, 122)));
  endtask

  task automatic push16(input int v);
    logic [15:0] t;
    t = 16'(v);
    rec_q.push_back(t[15:8]);
    rec_q.push_back(t[7:0]);
  endtask

  // Assemble a ClientHello record around nm_q.
  task automatic build_ch(input int sid, input int ncs, input int npre, input int pre_len,
                          input int pre_type, input bit with_sni, input bit with_post);
    int ext_start;
    logic [15:0] t;
    rec_q.delete();
    rec_q.push_back(8'h16); rec_q.push_back(8'h03); rec_q.push_back(8'h01);
    push16(0);
    rec_q.push_back(8'h01); rec_q.push_back(8'h00); push16(0);
    rec_q.push_back(8'h03); rec_q.push_back(8'h03);
    for (int i = 0; i < 32; i++) rec_q.push_back(8'($urandom));
    rec_q.push_back(8'(sid));
    for (int i = 0; i < sid; i++) rec_q.push_back(8'($urandom));
    push16(2 * ncs);
    for (int i = 0; i < 2 * ncs; i++) rec_q.push_back(8'($urandom));
    rec_q.push_back(8'h01); rec_q.push_back(8'h00);
    ext_start = rec_q.size();
    push16(0);
    for (int k = 0; k < npre; k++) begin
      push16(pre_type); push16(pre_len);
      for (int i = 0; i < pre_len; i++) rec_q.push_back(8'($urandom));
    end
    if (with_sni) begin
      push16(0); push16(5 + nm_q.size()); push16(3 + nm_q.size());
      rec_q.push_back(8'h00); push16(nm_q.size());
      for (int i = 0; i < nm_q.size(); i++) rec_q.push_back(nm_q[i]);
    end
    if (with_post) begin
      push16(16); push16(3);
      for (int i = 0; i < 3; i++) rec_q.push_back(8'($urandom));
    end
    t = 16'(rec_q.size() - ext_start - 2);
    rec_q[ext_start] = t[15:8]; rec_q[ext_start + 1] = t[7:0];
    t = 16'(rec_q.size() - 5);
    rec_q[3] = t[15:8]; rec_q[4] = t[7:0];
    t = 16'(rec_q.size() - 9);
    rec_q[7] = t[15:8]; rec_q[8] = t[7:0];
  endtask

  // Reference: locate fields by byte offset and mark the expected response
  // for each record byte (visible one cycle after that byte).
  task automatic run_model(input bit has_eop);
    int n, p, term, hdr, name_at, nlen, rem, typ, elen;
    logic [7:0] hold, b;
    n = rec_q.size();
    hold = 8'h00;
    for (int i = 0; i < MAXB; i++) begin
      e_v[i] = 1'b0; e_w[i] = 16'h0000; e_d[i] = 1'b0; e_e[i] = 1'b0;
    end
    term = BIG; hdr = -1; name_at = -1; nlen = 0;
    if (rd(0) != 8'h16) term = 0;
    else if (rd(5) != 8'h01) term = 5;
    else begin
      p = 43;
      p = p + 1 + rd(p);
      p = p + 2 + rd(p) * 256 + rd(p + 1);
      p = p + 1 + rd(p);
      rem = rd(p) * 256 + rd(p + 1);
      p = p + 2;
      if (rem == 0) term = p - 1;
      for (int k = 0; k < 64 && term == BIG && hdr < 0 && p + 3 < n; k++) begin
        typ  = rd(p) * 256 + rd(p + 1);
        elen = rd(p + 2) * 256 + rd(p + 3);
        rem  = (rem - 4 - elen) & 32'hFFFF;
        if (typ == 0) hdr = p + 4;
        else begin
          p = p + 4 + elen;
          if (rem == 0) term = p - 1;
        end
      end
      if (hdr >= 0) begin
        nlen = rd(hdr + 3) * 256 + rd(hdr + 4);
        if (nlen == 0) term = hdr + 4;
        else begin
          name_at = hdr + 5;
          term = name_at + nlen - 1;
        end
      end
    end
    if (name_at >= 0) begin
      for (int j = 0; j < nlen && name_at + j < n; j++) begin
        b = lc(rec_q[name_at + j]);
        if (j % 2 == 0) begin
          hold = b;
          if (j == nlen - 1) begin
            e_v[name_at + j] = 1'b1; e_w[name_at + j] = {b, 8'h00};
          end
        end else begin
          e_v[name_at + j] = 1'b1; e_w[name_at + j] = {hold, b};
        end
      end
    end
    if (hdr >= 0 && term < n) e_d[term] = 1'b1;
    m_len = 16'(nlen);
    if (has_eop && n > 0 && term >= n) e_e[n - 1] = 1'b1;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic s, input logic e,
                      input logic ev, input logic [15:0] ew, input logic ed, input logic ee);
    valid = v; data = d; sop = s; eop = e;
    @(posedge clk); #1;
    valid = 1'b0; sop = 1'b0; eop = 1'b0;
    chk_eq("valid", {31'd0, match_valid}, {31'd0, ev});
    if (ev) chk_eq("word", {16'd0, match_data}, {16'd0, ew});
    chk_eq("done", {31'd0, sni_done}, {31'd0, ed});
    chk_eq("err", {31'd0, parse_err}, {31'd0, ee});
    chk_eq("len", {16'd0, sni_len}, {16'd0, exp_len});
    if (match_valid) log_q.push_back(match_data);
    if (sni_done) begin n_done++; done_word = match_data; end
    if (parse_err) n_err++;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic feed(input int nb, input bit with_eop, input int maxgap, input bit tail);
    for (int i = 0; i < nb; i++) begin
      int g;
      g = $urandom_range(0, maxgap);
      for (int k = 0; k < g; k++) idle();
      if (i == 0) exp_len = 16'd0;
      if (e_d[i]) exp_len = m_len;
      step(1'b1, rec_q[i], i == 0, with_eop && (i == nb - 1), e_v[i], e_w[i], e_d[i], e_e[i]);
    end
    if (tail) begin idle(); idle(); end
  endtask

  task automatic clear_obs();
    log_q.delete(); n_done = 0; n_err = 0; done_word = 16'h0000;
  endtask

  task automatic check_www();
    logic [15:0] exp_w[5];
    exp_w = '{16'h7777, 16'h772E, 16'h612E, 16'h636F, 16'h6D00};
    chk_eq("www_count", 32'(log_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < log_q.size(); i++) chk_eq("www_word", {16'd0, log_q[i]}, {16'd0, exp_w[i]});
    chk_eq("www_done_word", {16'd0, done_word}, 32'h6D00);
    chk_eq("www_ndone", 32'(n_done), 32'd1);
    chk_eq("www_len", {16'd0, sni_len}, 32'd9);
  endtask

  initial begin
    int cut, sid, kind;
    logic [15:0] ab_word;
    n_cmp = 0; n_bad = 0; exp_len = 16'd0;
    rst = 1'b1; valid = 1'b0; data = 8'h00; sop = 1'b0; eop = 1'b0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_valid", {31'd0, match_valid}, 32'd0);
    chk_eq("rst_data", {16'd0, match_data}, 32'd0);
    chk_eq("rst_done", {31'd0, sni_done}, 32'd0);
    chk_eq("rst_err", {31'd0, parse_err}, 32'd0);
    chk_eq("rst_len", {16'd0, sni_len}, 32'd0);
    rst = 1'b0;
    idle();

    // Plain ClientHello, back-to-back bytes.
    set_name("www.a.com");
    build_ch(0, 1, 0, 0, 0, 1'b1, 1'b0);
    run_model(1'b1); clear_obs();
    feed(rec_q.size(), 1'b1, 0, 1'b1);
    check_www();

    // 32-byte session ID, preceding 0x000A extension, gapped bytes.
    build_ch(32, 1, 1, 8, 16'h000A, 1'b1, 1'b0);
    run_model(1'b1); clear_obs();
    feed(rec_q.size(), 1'b1, 3, 1'b1);
    check_www();

    // Application data record, then a normal ClientHello.
    build_ch(0, 1, 0, 0, 0, 1'b1, 1'b0);
    rec_q[0] = 8'h17;
    run_model(1'b1); clear_obs();
    feed(rec_q.size(), 1'b1, 1, 1'b1);
    chk_eq("appdata_words", 32'(log_q.size()), 32'd0);
    chk_eq("appdata_done", 32'(n_done), 32'd0);
    chk_eq("appdata_err", 32'(n_err), 32'd0);
    build_ch(0, 2, 0, 0, 0, 1'b1, 1'b1);
    run_model(1'b1); clear_obs();
    feed(rec_q.size(), 1'b1, 1, 1'b1);
    check_www();

    // Truncation right after the third name byte.
    set_name("abcd");
    build_ch(0, 1, 0, 0, 0, 1'b1, 1'b0);
    cut = rec_q.size() - 1;
    while (rec_q.size() > cut) void'(rec_q.pop_back());
    run_model(1'b1); clear_obs();
    feed(rec_q.size(), 1'b1, 2, 1'b1);
    chk_eq("trunc_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) chk_eq("trunc_word", {16'd0, log_q[0]}, 32'h6162);
    chk_eq("trunc_err", 32'(n_err), 32'd1);
    chk_eq("trunc_done", 32'(n_done), 32'd0);

    // SOP mid-record restarts the parse.
    set_name("zzzz.example");
    build_ch(4, 2, 0, 0, 0, 1'b1, 1'b0);
    run_model(1'b0);
    feed(50, 1'b0, 1, 1'b0);
    set_name("AB");
    build_ch(0, 1, 0, 0, 0, 1'b1, 1'b0);
    run_model(1'b1); clear_obs();
    feed(rec_q.size(), 1'b1, 1, 1'b1);
`ifdef SNI_LOWERCASE_EN
    ab_word = 16'h6162;
`else
    ab_word = 16'h4142;
`endif
    chk_eq("ab_count", 32'(log_q.size()), 32'd1);
    if (log_q.size() > 0) chk_eq("ab_word", {16'd0, log_q[0]}, {16'd0, ab_word});
    chk_eq("ab_len", {16'd0, sni_len}, 32'd2);
    chk_eq("ab_err", 32'(n_err), 32'd0);

    // Reset while a word is about to complete inside NAME.
    set_name("resetname.example.org");
    build_ch(0, 1, 0, 0, 0, 1'b1, 1'b0);
    run_model(1'b0);
    cut = rec_q.size() - nm_q.size() + 5;
    feed(cut, 1'b0, 1, 1'b0);
    rst = 1'b1; valid = 1'b1; data = rec_q[cut];
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0;
    exp_len = 16'd0;
    chk_eq("mid_rst_valid", {31'd0, match_valid}, 32'd0);
    chk_eq("mid_rst_data", {16'd0, match_data}, 32'd0);
    chk_eq("mid_rst_done", {31'd0, sni_done}, 32'd0);
    chk_eq("mid_rst_err", {31'd0, parse_err}, 32'd0);
    chk_eq("mid_rst_len", {16'd0, sni_len}, 32'd0);
    idle();
    build_ch(0, 1, 0, 0, 0, 1'b1, 1'b0);
    run_model(1'b1); clear_obs();
    feed(rec_q.size(), 1'b1, 0, 1'b1);
    chk_eq("post_rst_count", 32'(log_q.size()), 32'(nm_q.size() / 2 + nm_q.size() % 2));
    chk_eq("post_rst_len", {16'd0, sni_len}, 32'(nm_q.size()));

    // Randomized records.
    for (int r = 0; r < 40; r++) begin
      rand_name($urandom_range(0, 20));
      sid = $urandom_range(0, 32);
      build_ch(sid, $urandom_range(1, 4), $urandom_range(0, 2), $urandom_range(0, 10),
               $urandom_range(1, 65535), $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)));
      kind = $urandom_range(0, 9);
      if (kind == 0) rec_q[5] = 8'h02;
      if (kind == 1) begin
        cut = $urandom_range(1, rec_q.size());
        while (rec_q.size() > cut) void'(rec_q.pop_back());
      end
      run_model(1'b1); clear_obs();
      feed(rec_q.size(), 1'b1, 3, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
